// File: rtl/cvxif_issue_arbiter.sv
// -----------------------------------------------------------------------------
// cvxif_issue_arbiter
//
// Lets two cores share one CV-X-IF coprocessor.
//
//  Issue side : the two requesters are arbitrated round-robin. The winner's
//               instruction, operands and ID are forwarded to the coprocessor,
//               and the requester index is prepended to the ID so that results
//               can be routed back. A grant that is not accepted right away is
//               locked, so the coprocessor sees stable data until it accepts.
//  Result side: results are registered in a 1-entry buffer and presented to
//               the owning requester on a shared data bus. The buffer refills
//               in the same cycle that it drains, so back-to-back results need
//               no bubble cycles.
//  Accounting : each requester may have at most MaxOutstanding offloads in
//               flight. A result for a requester with nothing in flight is
//               still delivered, and err_o pulses for that cycle.
//
// Ports
//  clk_i, rst_ni        clock, asynchronous active-low reset
//  req_*_i / req_ready_o  issue channel from the two requesters. Vectors are
//                       flattened: requester r uses slice [r*W +: W]
//  co_valid_o ... co_id_o, co_ready_i
//                       issue channel to the coprocessor; co_id_o = {r, id}
//  co_res_*_i, co_res_ready_o
//                       result channel from the coprocessor (tagged ID)
//  res_valid_o[r], res_ready_i[r]
//                       per-requester result handshake
//  res_id_o, res_data_o, res_rd_o, res_we_o
//                       shared result bus, tag stripped from the ID
//  err_o                pulses when a result is delivered to a requester
//                       whose outstanding count is already zero
// -----------------------------------------------------------------------------
module cvxif_issue_arbiter #(
    parameter int unsigned XLEN           = 64,
    parameter int unsigned IdWidth        = 3,
    parameter int unsigned MaxOutstanding = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,

    input  logic [1:0]             req_valid_i,
    output logic [1:0]             req_ready_o,
    input  logic [2*32-1:0]        req_instr_i,
    input  logic [2*XLEN-1:0]      req_rs1_i,
    input  logic [2*XLEN-1:0]      req_rs2_i,
    input  logic [2*IdWidth-1:0]   req_id_i,

    output logic                   co_valid_o,
    input  logic                   co_ready_i,
    output logic [31:0]            co_instr_o,
    output logic [XLEN-1:0]        co_rs1_o,
    output logic [XLEN-1:0]        co_rs2_o,
    output logic [IdWidth:0]       co_id_o,

    input  logic                   co_res_valid_i,
    output logic                   co_res_ready_o,
    input  logic [IdWidth:0]       co_res_id_i,
    input  logic [XLEN-1:0]        co_res_data_i,
    input  logic [4:0]             co_res_rd_i,
    input  logic                   co_res_we_i,

    output logic [1:0]             res_valid_o,
    input  logic [1:0]             res_ready_i,
    output logic [IdWidth-1:0]     res_id_o,
    output logic [XLEN-1:0]        res_data_o,
    output logic [4:0]             res_rd_o,
    output logic                   res_we_o,

    output logic                   err_o
);

    localparam int unsigned         CntWidth = $clog2(MaxOutstanding + 1);
    localparam logic [CntWidth-1:0] CntMax   = CntWidth'(MaxOutstanding);

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_e;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_e              state_q;
    logic                lock_q;       // requester held while in LOCK
    logic                rr_q;         // preferred requester on a tie

    logic [CntWidth-1:0] cnt_q [2];
    logic [CntWidth-1:0] cnt_d [2];

    logic                buf_v_q;
    logic                buf_owner_q;
    logic [IdWidth-1:0]  buf_id_q;
    logic [XLEN-1:0]     buf_data_q;
    logic [4:0]          buf_rd_q;
    logic                buf_we_q;

    // -------------------------------------------------------------------------
    // Arbitration
    // -------------------------------------------------------------------------
    logic [1:0] eligible;
    logic       gnt;
    logic       gnt_valid;
    logic       issue_hs;

    // NOTE: every signal written here gets a default at the top of the block,
    // so no path through the if/case can leave it unassigned and infer a latch.
    always_comb begin
        gnt         = rr_q;
        gnt_valid   = 1'b0;
        eligible[0] = req_valid_i[0] && (cnt_q[0] < CntMax);
        eligible[1] = req_valid_i[1] && (cnt_q[1] < CntMax);

        if (state_q == LOCK) begin
            // The held requester keeps the grant whatever the other side does;
            // its count cannot have grown while locked, so no eligibility test.
            gnt       = lock_q;
            gnt_valid = req_valid_i[lock_q];
        end else begin
            case (eligible)
                2'b01:   gnt = 1'b0;
                2'b10:   gnt = 1'b1;
                default: gnt = rr_q;
            endcase
            gnt_valid = |eligible;
        end

        // Outputs read as zero while reset is asserted, even with requesters
        // still raising valid, so the coprocessor never sees a stale issue.
        gnt_valid = gnt_valid && rst_ni;
    end

    assign issue_hs    = gnt_valid && co_ready_i;
    assign co_valid_o  = gnt_valid;
    assign req_ready_o = {issue_hs && gnt, issue_hs && !gnt};

    // Forward the granted requester's payload; zeros when nothing is granted.
    always_comb begin
        co_instr_o = '0;
        co_rs1_o   = '0;
        co_rs2_o   = '0;
        co_id_o    = '0;
        if (gnt_valid) begin
            if (gnt) begin
                co_instr_o = req_instr_i[32 +: 32];
                co_rs1_o   = req_rs1_i[XLEN +: XLEN];
                co_rs2_o   = req_rs2_i[XLEN +: XLEN];
                co_id_o    = {1'b1, req_id_i[IdWidth +: IdWidth]};
            end else begin
                co_instr_o = req_instr_i[0 +: 32];
                co_rs1_o   = req_rs1_i[0 +: XLEN];
                co_rs2_o   = req_rs2_i[0 +: XLEN];
                co_id_o    = {1'b0, req_id_i[0 +: IdWidth]};
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            lock_q  <= 1'b0;
            rr_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (gnt_valid) begin
                        if (co_ready_i) begin
                            rr_q <= ~gnt;
                        end else begin
                            state_q <= LOCK;
                            lock_q  <= gnt;
                        end
                    end
                end
                LOCK: begin
                    if (!req_valid_i[lock_q]) begin
                        // Requester withdrew its issue: release without counting.
                        state_q <= IDLE;
                    end else if (co_ready_i) begin
                        state_q <= IDLE;
                        rr_q    <= ~lock_q;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Result buffer
    // -------------------------------------------------------------------------
    logic capture;
    logic deliver;

    assign deliver        = buf_v_q && res_ready_i[buf_owner_q];
    // A draining buffer can accept the next result in the same cycle.
    assign co_res_ready_o = rst_ni && (!buf_v_q || res_ready_i[buf_owner_q]);
    assign capture        = co_res_valid_i && co_res_ready_o;

    // NOTE: the payload registers are reset along with the valid bit because
    // they drive the shared result bus directly, which must read 0 after reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            buf_v_q     <= 1'b0;
            buf_owner_q <= 1'b0;
            buf_id_q    <= '0;
            buf_data_q  <= '0;
            buf_rd_q    <= '0;
            buf_we_q    <= 1'b0;
        end else if (capture) begin
            buf_v_q     <= 1'b1;
            buf_owner_q <= co_res_id_i[IdWidth];
            buf_id_q    <= co_res_id_i[IdWidth-1:0];
            buf_data_q  <= co_res_data_i;
            buf_rd_q    <= co_res_rd_i;
            buf_we_q    <= co_res_we_i;
        end else if (deliver) begin
            buf_v_q     <= 1'b0;
        end
    end

    assign res_valid_o = {buf_v_q && buf_owner_q, buf_v_q && !buf_owner_q};
    assign res_id_o    = buf_id_q;
    assign res_data_o  = buf_data_q;
    assign res_rd_o    = buf_rd_q;
    assign res_we_o    = buf_we_q;

    // -------------------------------------------------------------------------
    // Outstanding counters
    // -------------------------------------------------------------------------
    logic [1:0] inc;
    logic [1:0] dec;
    logic [1:0] cnt_zero;

    assign inc = req_ready_o;
    assign dec = res_valid_o & res_ready_i;

    always_comb begin
        for (int r = 0; r < 2; r++) begin
            cnt_zero[r] = (cnt_q[r] == '0);
            cnt_d[r]    = cnt_q[r];
            // A delivery against an empty count is flagged, never underflows.
            if (inc[r] && !(dec[r] && !cnt_zero[r])) begin
                cnt_d[r] = cnt_q[r] + CntWidth'(1);
            end else if (!inc[r] && dec[r] && !cnt_zero[r]) begin
                cnt_d[r] = cnt_q[r] - CntWidth'(1);
            end
        end
    end

    assign err_o = |(dec & cnt_zero);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int r = 0; r < 2; r++) begin
                cnt_q[r] <= '0;
            end
        end else begin
            for (int r = 0; r < 2; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
        end
    end

endmodule

// File: tb/tb_cvxif_issue_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cvxif_issue_arbiter
//
// Directed bench for cvxif_issue_arbiter. Inputs change just after the falling
// edge; outputs are sampled 1 ns later, well away from the rising edge.
// -----------------------------------------------------------------------------
module tb_cvxif_issue_arbiter;

    localparam int XLEN    = 64;
    localparam int IdWidth = 3;

    logic                 clk_i = 1'b0;
    logic                 rst_ni;
    logic [1:0]           req_valid_i;
    logic [1:0]           req_ready_o;
    logic [63:0]          req_instr_i;
    logic [2*XLEN-1:0]    req_rs1_i;
    logic [2*XLEN-1:0]    req_rs2_i;
    logic [2*IdWidth-1:0] req_id_i;
    logic                 co_valid_o;
    logic                 co_ready_i;
    logic [31:0]          co_instr_o;
    logic [XLEN-1:0]      co_rs1_o;
    logic [XLEN-1:0]      co_rs2_o;
    logic [IdWidth:0]     co_id_o;
    logic                 co_res_valid_i;
    logic                 co_res_ready_o;
    logic [IdWidth:0]     co_res_id_i;
    logic [XLEN-1:0]      co_res_data_i;
    logic [4:0]           co_res_rd_i;
    logic                 co_res_we_i;
    logic [1:0]           res_valid_o;
    logic [1:0]           res_ready_i;
    logic [IdWidth-1:0]   res_id_o;
    logic [XLEN-1:0]      res_data_o;
    logic [4:0]           res_rd_o;
    logic                 res_we_o;
    logic                 err_o;

    int checks = 0;
    int passes = 0;

    cvxif_issue_arbiter #(
        .XLEN           (XLEN),
        .IdWidth        (IdWidth),
        .MaxOutstanding (4)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_instr_i    (req_instr_i),
        .req_rs1_i      (req_rs1_i),
        .req_rs2_i      (req_rs2_i),
        .req_id_i       (req_id_i),
        .co_valid_o     (co_valid_o),
        .co_ready_i     (co_ready_i),
        .co_instr_o     (co_instr_o),
        .co_rs1_o       (co_rs1_o),
        .co_rs2_o       (co_rs2_o),
        .co_id_o        (co_id_o),
        .co_res_valid_i (co_res_valid_i),
        .co_res_ready_o (co_res_ready_o),
        .co_res_id_i    (co_res_id_i),
        .co_res_data_i  (co_res_data_i),
        .co_res_rd_i    (co_res_rd_i),
        .co_res_we_i    (co_res_we_i),
        .res_valid_o    (res_valid_o),
        .res_ready_i    (res_ready_i),
        .res_id_o       (res_id_o),
        .res_data_o     (res_data_o),
        .res_rd_o       (res_rd_o),
        .res_we_o       (res_we_o),
        .err_o          (err_o)
    );

    always #5 clk_i = ~clk_i;

    // -------------------------------------------------------------------------
    // Stimulus helpers
    // -------------------------------------------------------------------------
    task automatic clear_inputs();
        req_valid_i    = '0;
        req_instr_i    = '0;
        req_rs1_i      = '0;
        req_rs2_i      = '0;
        req_id_i       = '0;
        co_ready_i     = 1'b0;
        co_res_valid_i = 1'b0;
        co_res_id_i    = '0;
        co_res_data_i  = '0;
        co_res_rd_i    = '0;
        co_res_we_i    = 1'b0;
        res_ready_i    = '0;
    endtask

    // Returns just after a falling edge with reset released.
    task automatic apply_reset();
        @(negedge clk_i);
        clear_inputs();
        rst_ni = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    task automatic set_req(input int r, input logic [31:0] instr,
                           input logic [XLEN-1:0] rs1, input logic [XLEN-1:0] rs2,
                           input logic [IdWidth-1:0] id);
        req_instr_i[r*32 +: 32]           = instr;
        req_rs1_i[r*XLEN +: XLEN]         = rs1;
        req_rs2_i[r*XLEN +: XLEN]         = rs2;
        req_id_i[r*IdWidth +: IdWidth]    = id;
    endtask

    task automatic set_res(input logic valid, input logic [IdWidth:0] id,
                           input logic [XLEN-1:0] data, input logic [4:0] rd,
                           input logic we);
        co_res_valid_i = valid;
        co_res_id_i    = id;
        co_res_data_i  = data;
        co_res_rd_i    = rd;
        co_res_we_i    = we;
    endtask

    // -------------------------------------------------------------------------
    // Reset values, then the empty buffer once reset is released
    // -------------------------------------------------------------------------
    task automatic test_reset();
        clear_inputs();
        rst_ni = 1'b0;
        #12;
        checks++; if (co_valid_o !== 1'b0) $display("FAIL reset_co_valid: got %b want 0", co_valid_o); else passes++;
        checks++; if (req_ready_o !== 2'b00) $display("FAIL reset_req_ready: got %b want 00", req_ready_o); else passes++;
        checks++; if (co_res_ready_o !== 1'b0) $display("FAIL reset_co_res_ready: got %b want 0", co_res_ready_o); else passes++;
        checks++; if (res_valid_o !== 2'b00) $display("FAIL reset_res_valid: got %b want 00", res_valid_o); else passes++;
        checks++; if ({co_id_o, res_id_o, res_data_o, err_o} !== '0) $display("FAIL reset_buses: got id=%h rid=%h data=%h err=%b want 0", co_id_o, res_id_o, res_data_o, err_o); else passes++;
        @(negedge clk_i);
        rst_ni = 1'b1;
        #1;
        checks++; if (co_res_ready_o !== 1'b1) $display("FAIL post_reset_co_res_ready: got %b want 1", co_res_ready_o); else passes++;
    endtask

    // -------------------------------------------------------------------------
    // Both requesting with the coprocessor always ready: grants alternate
    // -------------------------------------------------------------------------
    task automatic test_round_robin();
        logic            exp_g;
        logic [IdWidth:0] exp_id;
        logic [31:0]     exp_instr;
        apply_reset();
        set_req(0, 32'hA000_0000, 64'h10, 64'h20, 3'd2);
        set_req(1, 32'hB000_0001, 64'h11, 64'h21, 3'd6);
        req_valid_i = 2'b11;
        co_ready_i  = 1'b1;
        exp_g = 1'b0;
        for (int k = 0; k < 4; k++) begin
            exp_id    = exp_g ? 4'b1110 : 4'b0010;
            exp_instr = exp_g ? 32'hB000_0001 : 32'hA000_0000;
            #1;
            checks++; if (co_id_o !== exp_id) $display("FAIL rr_id_c%0d: got %h want %h", k, co_id_o, exp_id); else passes++;
            checks++; if (req_ready_o !== (exp_g ? 2'b10 : 2'b01)) $display("FAIL rr_ready_c%0d: got %b want %b", k, req_ready_o, exp_g ? 2'b10 : 2'b01); else passes++;
            checks++; if (co_instr_o !== exp_instr) $display("FAIL rr_instr_c%0d: got %h want %h", k, co_instr_o, exp_instr); else passes++;
            @(negedge clk_i);
            exp_g = ~exp_g;
        end
        clear_inputs();
    endtask

    // -------------------------------------------------------------------------
    // Locked grant holds against the other requester; withdrawal releases it
    // -------------------------------------------------------------------------
    task automatic test_lock();
        apply_reset();
        set_req(0, 32'h0000_C0DE, 64'hAAAA, 64'hBBBB, 3'd4);
        set_req(1, 32'h0000_F00D, 64'hCCCC, 64'hDDDD, 3'd1);
        // One accepted issue from requester 0 moves the pointer to 1.
        req_valid_i = 2'b01;
        co_ready_i  = 1'b1;
        #1;
        checks++; if (req_ready_o !== 2'b01) $display("FAIL lock_pre_ready: got %b want 01", req_ready_o); else passes++;
        @(negedge clk_i);
        // Requester 0 alone, not accepted: grant locks on 0.
        co_ready_i = 1'b0;
        #1;
        checks++; if ({co_valid_o, req_ready_o} !== 3'b100) $display("FAIL lock_enter: got valid=%b ready=%b want 1/00", co_valid_o, req_ready_o); else passes++;
        @(negedge clk_i);
        // Requester 1 joins; the pointer favours it, the lock must not.
        req_valid_i = 2'b11;
        for (int k = 0; k < 2; k++) begin
            #1;
            checks++; if (co_id_o !== 4'b0100) $display("FAIL lock_hold_id_c%0d: got %h want 4", k, co_id_o); else passes++;
            checks++; if ({co_instr_o, co_rs1_o, co_rs2_o} !== {32'h0000_C0DE, 64'hAAAA, 64'hBBBB}) $display("FAIL lock_hold_data_c%0d: got %h %h %h", k, co_instr_o, co_rs1_o, co_rs2_o); else passes++;
            checks++; if (req_ready_o !== 2'b00) $display("FAIL lock_hold_ready_c%0d: got %b want 00", k, req_ready_o); else passes++;
            @(negedge clk_i);
        end
        co_ready_i = 1'b1;
        #1;
        checks++; if (req_ready_o !== 2'b01) $display("FAIL lock_accept: got %b want 01", req_ready_o); else passes++;
        @(negedge clk_i);
        req_valid_i = 2'b10;
        #1;
        checks++; if ({req_ready_o, co_id_o} !== {2'b10, 4'b1001}) $display("FAIL lock_next_grant: got ready=%b id=%h want 10/9", req_ready_o, co_id_o); else passes++;
        @(negedge clk_i);
        // Lock on 0 again, then requester 0 withdraws.
        req_valid_i = 2'b01;
        co_ready_i  = 1'b0;
        #1;
        checks++; if (co_id_o !== 4'b0100) $display("FAIL lock2_enter: got %h want 4", co_id_o); else passes++;
        @(negedge clk_i);
        req_valid_i = 2'b10;
        #1;
        checks++; if (co_valid_o !== 1'b0) $display("FAIL lock_withdraw_valid: got %b want 0", co_valid_o); else passes++;
        @(negedge clk_i);
        #1;
        checks++; if ({co_valid_o, co_id_o} !== {1'b1, 4'b1001}) $display("FAIL lock_release_grant: got valid=%b id=%h want 1/9", co_valid_o, co_id_o); else passes++;
        clear_inputs();
    endtask

    // -------------------------------------------------------------------------
    // Outstanding limit: 4 issues block requester 0 until a result returns
    // -------------------------------------------------------------------------
    task automatic test_outstanding();
        apply_reset();
        set_req(0, 32'h1111_0000, 64'h1, 64'h2, 3'd0);
        set_req(1, 32'h2222_0000, 64'h3, 64'h4, 3'd3);
        req_valid_i = 2'b01;
        co_ready_i  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++; if (req_ready_o !== 2'b01) $display("FAIL out_issue_c%0d: got %b want 01", k, req_ready_o); else passes++;
            @(negedge clk_i);
        end
        #1;
        checks++; if ({co_valid_o, req_ready_o} !== 3'b000) $display("FAIL out_full: got valid=%b ready=%b want 0/00", co_valid_o, req_ready_o); else passes++;
        @(negedge clk_i);
        req_valid_i = 2'b11;
        #1;
        checks++; if ({req_ready_o, co_id_o} !== {2'b10, 4'b1011}) $display("FAIL out_other_served: got ready=%b id=%h want 10/b", req_ready_o, co_id_o); else passes++;
        @(negedge clk_i);
        req_valid_i = 2'b01;
        res_ready_i = 2'b01;
        set_res(1'b1, 4'b0000, 64'h5A5A, 5'd1, 1'b1);
        #1;
        checks++; if (co_valid_o !== 1'b0) $display("FAIL out_still_full: got %b want 0", co_valid_o); else passes++;
        @(negedge clk_i);
        co_res_valid_i = 1'b0;
        #1;
        checks++; if ({res_valid_o, co_valid_o} !== 3'b010) $display("FAIL out_deliver: got res_valid=%b co_valid=%b want 01/0", res_valid_o, co_valid_o); else passes++;
        @(negedge clk_i);
        #1;
        checks++; if ({co_valid_o, req_ready_o} !== 3'b101) $display("FAIL out_reopen: got valid=%b ready=%b want 1/01", co_valid_o, req_ready_o); else passes++;
        clear_inputs();
    endtask

    // -------------------------------------------------------------------------
    // Stalled result for requester 1, then delivery with same-cycle refill
    // -------------------------------------------------------------------------
    task automatic test_result_stall();
        apply_reset();
        set_req(1, 32'h3333_0000, 64'h7, 64'h8, 3'd5);
        req_valid_i = 2'b10;
        co_ready_i  = 1'b1;
        #1;
        checks++; if (req_ready_o !== 2'b10) $display("FAIL stall_issue: got %b want 10", req_ready_o); else passes++;
        @(negedge clk_i);
        req_valid_i = 2'b00;
        set_res(1'b1, 4'b1101, 64'hDEAD_BEEF_0000_0001, 5'd7, 1'b1);
        #1;
        checks++; if (co_res_ready_o !== 1'b1) $display("FAIL stall_capture_ready: got %b want 1", co_res_ready_o); else passes++;
        @(negedge clk_i);
        set_res(1'b1, 4'b1001, 64'h0000_0000_CAFE_0002, 5'd3, 1'b0);
        for (int k = 0; k < 2; k++) begin
            #1;
            checks++; if ({res_valid_o, co_res_ready_o} !== 3'b100) $display("FAIL stall_hold_c%0d: got res_valid=%b co_res_ready=%b want 10/0", k, res_valid_o, co_res_ready_o); else passes++;
            checks++; if ({res_id_o, res_data_o} !== {3'd5, 64'hDEAD_BEEF_0000_0001}) $display("FAIL stall_hold_data_c%0d: got id=%h data=%h", k, res_id_o, res_data_o); else passes++;
            @(negedge clk_i);
        end
        res_ready_i = 2'b10;
        #1;
        checks++; if ({co_res_ready_o, err_o, res_rd_o, res_we_o} !== {1'b1, 1'b0, 5'd7, 1'b1}) $display("FAIL stall_release: got ready=%b err=%b rd=%0d we=%b want 1/0/7/1", co_res_ready_o, err_o, res_rd_o, res_we_o); else passes++;
        @(negedge clk_i);
        co_res_valid_i = 1'b0;
        #1;
        checks++; if ({res_valid_o, res_id_o, res_data_o, res_we_o} !== {2'b10, 3'd1, 64'h0000_0000_CAFE_0002, 1'b0}) $display("FAIL stall_refill: got v=%b id=%h data=%h we=%b", res_valid_o, res_id_o, res_data_o, res_we_o); else passes++;
        // Count for requester 1 went 1 -> 0 on the first delivery.
        checks++; if (err_o !== 1'b1) $display("FAIL stall_count_empty_err: got %b want 1", err_o); else passes++;
        @(negedge clk_i);
        #1;
        checks++; if ({res_valid_o, err_o} !== 3'b000) $display("FAIL stall_drained: got v=%b err=%b want 00/0", res_valid_o, err_o); else passes++;
        clear_inputs();
    endtask

    // -------------------------------------------------------------------------
    // Back-to-back results for alternating owners: one delivery per cycle
    // -------------------------------------------------------------------------
    task automatic test_back_to_back();
        logic [1:0]      owner [4];
        logic [IdWidth-1:0] id [4];
        logic [XLEN-1:0] data [4];
        owner = '{2'b01, 2'b10, 2'b01, 2'b10};
        id    = '{3'd1, 3'd2, 3'd3, 3'd4};
        data  = '{64'h100, 64'h201, 64'h302, 64'h403};
        apply_reset();
        res_ready_i = 2'b11;
        for (int k = 0; k < 5; k++) begin
            if (k < 4) set_res(1'b1, {owner[k][1], id[k]}, data[k], 5'(k), 1'b1);
            else       co_res_valid_i = 1'b0;
            #1;
            checks++; if (co_res_ready_o !== 1'b1) $display("FAIL b2b_ready_c%0d: got %b want 1", k, co_res_ready_o); else passes++;
            if (k > 0) begin
                checks++; if ({res_valid_o, res_id_o, res_data_o} !== {owner[k-1], id[k-1], data[k-1]}) $display("FAIL b2b_deliver_c%0d: got v=%b id=%h data=%h want %b/%h/%h", k, res_valid_o, res_id_o, res_data_o, owner[k-1], id[k-1], data[k-1]); else passes++;
                checks++; if (err_o !== 1'b1) $display("FAIL b2b_err_c%0d: got %b want 1", k, err_o); else passes++;
            end
            @(negedge clk_i);
        end
        #1;
        checks++; if (res_valid_o !== 2'b00) $display("FAIL b2b_empty: got %b want 00", res_valid_o); else passes++;
        clear_inputs();
    endtask

    // -------------------------------------------------------------------------
    // Stray result raises err without underflow; reset while locked
    // -------------------------------------------------------------------------
    task automatic test_err_and_reset();
        apply_reset();
        set_req(0, 32'h4444_0000, 64'h9, 64'hA, 3'd6);
        set_req(1, 32'h5555_0000, 64'hB, 64'hC, 3'd7);
        res_ready_i = 2'b01;
        set_res(1'b1, 4'b0011, 64'hEE, 5'd2, 1'b1);
        @(negedge clk_i);
        co_res_valid_i = 1'b0;
        #1;
        checks++; if ({res_valid_o, err_o} !== 3'b011) $display("FAIL err_pulse: got v=%b err=%b want 01/1", res_valid_o, err_o); else passes++;
        @(negedge clk_i);
        #1;
        checks++; if ({res_valid_o, err_o} !== 3'b000) $display("FAIL err_one_cycle: got v=%b err=%b want 00/0", res_valid_o, err_o); else passes++;
        // Count stayed 0 (not wrapped), so requester 0 is still eligible.
        req_valid_i = 2'b01;
        co_ready_i  = 1'b1;
        #1;
        checks++; if (req_ready_o !== 2'b01) $display("FAIL err_no_underflow: got %b want 01", req_ready_o); else passes++;
        @(negedge clk_i);
        co_ready_i  = 1'b0;
        res_ready_i = 2'b00;
        set_res(1'b1, 4'b0010, 64'h77, 5'd4, 1'b1);
        #1;
        checks++; if ({co_valid_o, req_ready_o} !== 3'b100) $display("FAIL rst_lock_enter: got valid=%b ready=%b want 1/00", co_valid_o, req_ready_o); else passes++;
        @(negedge clk_i);
        co_res_valid_i = 1'b0;
        #1;
        checks++; if ({co_valid_o, res_valid_o} !== 3'b101) $display("FAIL rst_pre: got valid=%b res_valid=%b want 1/01", co_valid_o, res_valid_o); else passes++;
        rst_ni = 1'b0;
        #1;
        checks++; if ({co_valid_o, req_ready_o, co_res_ready_o, res_valid_o, err_o} !== 7'b0) $display("FAIL rst_mid_ctrl: got %b %b %b %b %b want all 0", co_valid_o, req_ready_o, co_res_ready_o, res_valid_o, err_o); else passes++;
        checks++; if ({co_id_o, co_instr_o, res_id_o, res_data_o} !== '0) $display("FAIL rst_mid_buses: got id=%h instr=%h rid=%h data=%h want 0", co_id_o, co_instr_o, res_id_o, res_data_o); else passes++;
        @(negedge clk_i);
        rst_ni      = 1'b1;
        req_valid_i = 2'b11;
        co_ready_i  = 1'b1;
        #1;
        checks++; if ({res_valid_o, co_res_ready_o} !== 3'b001) $display("FAIL rst_buffer_dropped: got v=%b ready=%b want 00/1", res_valid_o, co_res_ready_o); else passes++;
        checks++; if ({req_ready_o, co_id_o} !== {2'b01, 4'b0110}) $display("FAIL rst_pointer: got ready=%b id=%h want 01/6", req_ready_o, co_id_o); else passes++;
        @(negedge clk_i);
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_lock();
        test_outstanding();
        test_result_stall();
        test_back_to_back();
        test_err_and_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", passes, checks);
        $fatal(1);
    end

endmodule
